// File: rtl/control_ejecucion_pipeline_if.sv
// Command/halt handshake and pipeline-control outputs of control_ejecucion_pipeline.
// The sequencer binds the slave modport; whoever drives commands uses master.
interface control_ejecucion_pipeline_if #(
    parameter int unsigned CANT_BITS_CMD      = 8,
    parameter int unsigned CANT_BITS_CONTADOR = 32
);
    logic                          i_cmd_valid;
    logic [CANT_BITS_CMD-1:0]      i_cmd_data;
    logic                          i_halt_detected;
    logic                          o_cmd_ready;
    logic                          o_enable_pipeline;
    logic                          o_reset_pipeline;
    logic [CANT_BITS_CONTADOR-1:0] o_cycle_count;
    logic                          o_done;
    logic                          o_timeout;
    logic [2:0]                    o_estado;

    modport slave (
        input  i_cmd_valid, i_cmd_data, i_halt_detected,
        output o_cmd_ready, o_enable_pipeline, o_reset_pipeline,
               o_cycle_count, o_done, o_timeout, o_estado
    );

    modport master (
        output i_cmd_valid, i_cmd_data, i_halt_detected,
        input  o_cmd_ready, o_enable_pipeline, o_reset_pipeline,
               o_cycle_count, o_done, o_timeout, o_estado
    );
endinterface

// File: rtl/control_ejecucion_pipeline.sv
// Pipeline-enable sequencer: runs the MIPS pipeline continuously or step by step from UART debug commands.
// Optional continuous-run watchdog enabled by defining WATCHDOG_EN.
module control_ejecucion_pipeline #(
    parameter int unsigned CANT_BITS_CMD      = 8,
    parameter int unsigned CANT_BITS_CONTADOR = 32,
    parameter int unsigned CICLOS_RESET       = 4,
    parameter int unsigned CICLOS_WATCHDOG    = 1024
) (
    input  logic                          i_clock,
    input  logic                          i_soft_reset,
    control_ejecucion_pipeline_if.slave   bus
);
    localparam int unsigned RST_W = (CICLOS_RESET > 1) ? $clog2(CICLOS_RESET) : 1;

    localparam logic [CANT_BITS_CMD-1:0] CMD_CONTINUO    = CANT_BITS_CMD'(8'h01);
    localparam logic [CANT_BITS_CMD-1:0] CMD_PASO_A_PASO = CANT_BITS_CMD'(8'h02);
    localparam logic [CANT_BITS_CMD-1:0] CMD_STEP        = CANT_BITS_CMD'(8'h03);
    localparam logic [CANT_BITS_CMD-1:0] CMD_ABORT       = CANT_BITS_CMD'(8'h04);

    localparam logic [RST_W-1:0]              RST_LAST   = RST_W'(CICLOS_RESET - 1);
    localparam logic [CANT_BITS_CONTADOR-1:0] CNT_MAX    = {CANT_BITS_CONTADOR{1'b1}};
    localparam logic [CANT_BITS_CONTADOR-1:0] WD_LAST    = CANT_BITS_CONTADOR'(CICLOS_WATCHDOG - 1);
`ifdef WATCHDOG_EN
    localparam bit WATCHDOG_ACTIVO = 1'b1;
`else
    localparam bit WATCHDOG_ACTIVO = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        RESET_PIPE  = 3'd1,
        RUN_CONT    = 3'd2,
        ESPERA_PASO = 3'd3,
        EJEC_PASO   = 3'd4,
        DONE        = 3'd5
    } estado_t;

    estado_t                       state_q, state_d;
    logic                          modo_paso_q, modo_paso_d;
    logic [RST_W-1:0]              rst_cnt_q, rst_cnt_d;
    logic [CANT_BITS_CONTADOR-1:0] count_q, count_d;
    logic                          done_q, done_d;
    logic                          timeout_q, timeout_d;
    logic                          enable_q, reset_pipe_q, ready_q;

    logic cmd_take, cmd_start, cmd_abort, cmd_step, wd_hit;

    always_comb begin
        cmd_take  = bus.i_cmd_valid && ready_q;
        cmd_start = cmd_take && (bus.i_cmd_data == CMD_CONTINUO || bus.i_cmd_data == CMD_PASO_A_PASO);
        cmd_abort = cmd_take && (bus.i_cmd_data == CMD_ABORT);
        cmd_step  = cmd_take && (bus.i_cmd_data == CMD_STEP);
        wd_hit    = WATCHDOG_ACTIVO && (count_q == WD_LAST);
    end

    // Next state and next values of every registered output
    always_comb begin
        state_d     = state_q;
        modo_paso_d = modo_paso_q;
        rst_cnt_d   = rst_cnt_q;
        count_d     = count_q;
        done_d      = done_q;
        timeout_d   = timeout_q;

        // The counter tracks cycles in which the pipeline enable is high
        if ((state_q == RUN_CONT || state_q == EJEC_PASO) && count_q != CNT_MAX)
            count_d = count_q + CANT_BITS_CONTADOR'(1);

        unique case (state_q)
            IDLE, DONE: begin
                if (cmd_start) begin
                    modo_paso_d = (bus.i_cmd_data == CMD_PASO_A_PASO);
                    state_d     = RESET_PIPE;
                    rst_cnt_d   = '0;
                    count_d     = '0;
                    done_d      = 1'b0;
                    timeout_d   = 1'b0;
                end else if (cmd_abort && state_q == DONE) begin
                    state_d   = IDLE;
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            RESET_PIPE: begin
                count_d = '0;
                if (rst_cnt_q == RST_LAST)
                    state_d = modo_paso_q ? ESPERA_PASO : RUN_CONT;
                else
                    rst_cnt_d = rst_cnt_q + RST_W'(1);
            end
            RUN_CONT: begin
                // ABORT outranks a simultaneous halt; halt outranks the watchdog
                if (cmd_abort) begin
                    state_d   = IDLE;
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                end else if (bus.i_halt_detected) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (wd_hit) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                end
            end
            ESPERA_PASO: begin
                if (cmd_abort) begin
                    state_d   = IDLE;
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                end else if (cmd_step) begin
                    state_d = EJEC_PASO;
                end
            end
            EJEC_PASO: begin
                if (bus.i_halt_detected) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ESPERA_PASO;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_soft_reset) begin
        if (i_soft_reset) begin
            state_q      <= IDLE;
            modo_paso_q  <= 1'b0;
            rst_cnt_q    <= '0;
            count_q      <= '0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            enable_q     <= 1'b0;
            reset_pipe_q <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            modo_paso_q  <= modo_paso_d;
            rst_cnt_q    <= rst_cnt_d;
            count_q      <= count_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
            enable_q     <= (state_d == RUN_CONT) || (state_d == EJEC_PASO);
            reset_pipe_q <= (state_d == RESET_PIPE);
            // In RUN_CONT only ABORT acts on an accepted byte; other codes are dropped
            ready_q      <= (state_d == IDLE) || (state_d == RUN_CONT) ||
                            (state_d == ESPERA_PASO) || (state_d == DONE);
        end
    end

    assign bus.o_cmd_ready       = ready_q;
    assign bus.o_enable_pipeline = enable_q;
    assign bus.o_reset_pipeline  = reset_pipe_q;
    assign bus.o_cycle_count     = count_q;
    assign bus.o_done            = done_q;
    assign bus.o_timeout         = timeout_q;
    assign bus.o_estado          = state_q;
endmodule

// File: tb/tb_control_ejecucion_pipeline.sv
// Directed bench for control_ejecucion_pipeline: continuous, step, abort, soft reset, watchdog/saturation.
module tb_control_ejecucion_pipeline;
    localparam int unsigned CMD_W = 8;
    localparam int unsigned CNT_W = 5;

    localparam logic [7:0] CONTINUO    = 8'h01;
    localparam logic [7:0] PASO_A_PASO = 8'h02;
    localparam logic [7:0] STEP        = 8'h03;
    localparam logic [7:0] ABORT       = 8'h04;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_rst;
    int   n_en;

    always #5 clk = ~clk;

    control_ejecucion_pipeline_if #(.CANT_BITS_CMD(CMD_W), .CANT_BITS_CONTADOR(CNT_W)) bif ();

    control_ejecucion_pipeline #(
        .CANT_BITS_CMD(CMD_W),
        .CANT_BITS_CONTADOR(CNT_W),
        .CICLOS_RESET(4),
        .CICLOS_WATCHDOG(16)
    ) dut (
        .i_clock(clk),
        .i_soft_reset(rst),
        .bus(bif)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic [7:0] code);
        bif.i_cmd_valid = 1'b1;
        bif.i_cmd_data  = code;
        tick();
        bif.i_cmd_valid = 1'b0;
        bif.i_cmd_data  = 8'h00;
    endtask

    task automatic wait_reset(output int n);
        n = 0;
        while (bif.o_reset_pipeline && n < 20) begin
            n++;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "bench time limit expired");
    end

    initial begin
        rst                 = 1'b1;
        bif.i_cmd_valid     = 1'b0;
        bif.i_cmd_data      = 8'h00;
        bif.i_halt_detected = 1'b0;
        tick();
        tick();
        check("rst_estado", 32'(bif.o_estado), 0);
        check("rst_enable", 32'(bif.o_enable_pipeline), 0);
        check("rst_reset_pipe", 32'(bif.o_reset_pipeline), 0);
        check("rst_count", 32'(bif.o_cycle_count), 0);
        check("rst_done", 32'(bif.o_done), 0);
        check("rst_timeout", 32'(bif.o_timeout), 0);
        check("rst_ready", 32'(bif.o_cmd_ready), 1);
        rst = 1'b0;
        tick();

        // 1: continuous run, halt on the 10th enabled cycle
        send_cmd(CONTINUO);
        check("t1_estado_reset", 32'(bif.o_estado), 1);
        check("t1_ready_in_reset", 32'(bif.o_cmd_ready), 0);
        check("t1_enable_in_reset", 32'(bif.o_enable_pipeline), 0);
        wait_reset(n_rst);
        check("t1_reset_cycles", 32'(n_rst), 4);
        n_en = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 9) bif.i_halt_detected = 1'b1;
            if (bif.o_enable_pipeline) n_en++;
            tick();
        end
        bif.i_halt_detected = 1'b0;
        check("t1_enable_cycles", 32'(n_en), 10);
        check("t1_count", 32'(bif.o_cycle_count), 10);
        check("t1_done", 32'(bif.o_done), 1);
        check("t1_estado", 32'(bif.o_estado), 5);
        check("t1_enable_off", 32'(bif.o_enable_pipeline), 0);

        // 2: step mode, three STEPs five cycles apart
        send_cmd(PASO_A_PASO);
        check("t2_count_cleared", 32'(bif.o_cycle_count), 0);
        check("t2_done_cleared", 32'(bif.o_done), 0);
        wait_reset(n_rst);
        check("t2_estado_espera", 32'(bif.o_estado), 3);
        n_en = 0;
        for (int k = 0; k < 3; k++) begin
            send_cmd(STEP);
            if (bif.o_enable_pipeline) n_en++;
            if (k == 0) begin
                check("t2_estado_ejec", 32'(bif.o_estado), 4);
                check("t2_ready_ejec", 32'(bif.o_cmd_ready), 0);
            end
            for (int j = 0; j < 4; j++) begin
                tick();
                if (bif.o_enable_pipeline) n_en++;
            end
            check("t2_estado_between", 32'(bif.o_estado), 3);
        end
        check("t2_enable_cycles", 32'(n_en), 3);
        check("t2_count", 32'(bif.o_cycle_count), 3);

        // 3: abort from step wait, then halt during the second STEP
        send_cmd(ABORT);
        check("t3_abort_estado", 32'(bif.o_estado), 0);
        check("t3_abort_count_hold", 32'(bif.o_cycle_count), 3);
        send_cmd(PASO_A_PASO);
        wait_reset(n_rst);
        send_cmd(STEP);
        tick();
        tick();
        send_cmd(STEP);
        bif.i_halt_detected = 1'b1;
        tick();
        bif.i_halt_detected = 1'b0;
        check("t3_estado_done", 32'(bif.o_estado), 5);
        check("t3_count", 32'(bif.o_cycle_count), 2);
        check("t3_done", 32'(bif.o_done), 1);
        send_cmd(STEP);
        tick();
        check("t3_step_ignored_estado", 32'(bif.o_estado), 5);
        check("t3_step_ignored_count", 32'(bif.o_cycle_count), 2);
        check("t3_step_ignored_enable", 32'(bif.o_enable_pipeline), 0);

        // 4: ABORT coincident with halt in continuous mode, on the 6th enabled cycle
        send_cmd(CONTINUO);
        wait_reset(n_rst);
        repeat (5) tick();
        bif.i_halt_detected = 1'b1;
        bif.i_cmd_valid     = 1'b1;
        bif.i_cmd_data      = ABORT;
        tick();
        bif.i_halt_detected = 1'b0;
        bif.i_cmd_valid     = 1'b0;
        bif.i_cmd_data      = 8'h00;
        check("t4_estado", 32'(bif.o_estado), 0);
        check("t4_enable", 32'(bif.o_enable_pipeline), 0);
        check("t4_done", 32'(bif.o_done), 0);
        check("t4_count_hold", 32'(bif.o_cycle_count), 6);

        // 5: soft reset mid-run, asynchronous
        send_cmd(CONTINUO);
        wait_reset(n_rst);
        repeat (3) tick();
        rst = 1'b1;
        #1;
        check("t5_estado", 32'(bif.o_estado), 0);
        check("t5_enable", 32'(bif.o_enable_pipeline), 0);
        check("t5_count", 32'(bif.o_cycle_count), 0);
        check("t5_ready", 32'(bif.o_cmd_ready), 1);
        tick();
        rst = 1'b0;
        tick();
        send_cmd(CONTINUO);
        wait_reset(n_rst);
        check("t5_rerun_estado", 32'(bif.o_estado), 2);
        check("t5_rerun_count0", 32'(bif.o_cycle_count), 0);
        repeat (2) tick();
        check("t5_rerun_count2", 32'(bif.o_cycle_count), 2);
        send_cmd(ABORT);

        // 6: no halt for 40 cycles: watchdog at 16, else saturation at 31
        send_cmd(CONTINUO);
        wait_reset(n_rst);
        repeat (40) tick();
`ifdef WATCHDOG_EN
        check("t6_wd_estado", 32'(bif.o_estado), 5);
        check("t6_wd_count", 32'(bif.o_cycle_count), 16);
        check("t6_wd_timeout", 32'(bif.o_timeout), 1);
        check("t6_wd_done", 32'(bif.o_done), 1);
`else
        check("t6_run_estado", 32'(bif.o_estado), 2);
        check("t6_sat_count", 32'(bif.o_cycle_count), 31);
        check("t6_timeout", 32'(bif.o_timeout), 0);
        check("t6_enable", 32'(bif.o_enable_pipeline), 1);
`endif
        send_cmd(ABORT);
        check("t6_abort_estado", 32'(bif.o_estado), 0);
        check("t6_abort_timeout", 32'(bif.o_timeout), 0);
        check("t6_abort_done", 32'(bif.o_done), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
